// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multicycle MIPS sequencer producing the ALU op code and all datapath enables.
module mips_multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       rs_is_zero,
    input  logic       alu_bit0,
    input  logic       waitrequest,
    output logic [4:0] alu_control,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       mem_read,
    output logic       mem_write,
    output logic       addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic       wb_sel,
    output logic [1:0] pc_src,
    output logic       active,
    output logic       illegal
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
    localparam logic [4:0] ALU_AND = 5'b00000, ALU_OR = 5'b00001, ALU_ADD = 5'b00010, ALU_XOR = 5'b00011,
                           ALU_SLL = 5'b00100, ALU_SRL = 5'b00101, ALU_SUB = 5'b00110, ALU_SLT = 5'b00111,
                           ALU_SRA = 5'b01000, ALU_SLTU = 5'b01001, ALU_EQ = 5'b01010, ALU_LINK = 5'b01011,
                           ALU_PASSA = 5'b01110, ALU_LEZ = 5'b10000;
    state_t     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic [4:0] r_code, i_code;
    logic [1:0] i_srcb;
    logic       r_legal, i_alu;
    logic       is_r, is_jr, is_jalr, is_shift, is_lw, is_sw, is_br, is_j, is_jal, legal, br_take;
    always_comb begin
        r_code = ALU_AND;
        r_legal = 1'b1;
        case (funct)
            6'h21: r_code = ALU_ADD;
            6'h23: r_code = ALU_SUB;
            6'h24: r_code = ALU_AND;
            6'h25: r_code = ALU_OR;
            6'h26: r_code = ALU_XOR;
            6'h2a: r_code = ALU_SLT;
            6'h2b: r_code = ALU_SLTU;
            6'h00: r_code = ALU_SLL;
            6'h02: r_code = ALU_SRL;
            6'h03: r_code = ALU_SRA;
            6'h08: r_code = ALU_PASSA;
            6'h09: r_code = ALU_LINK;
            default: r_legal = 1'b0;
        endcase
    end
    always_comb begin
        i_code = ALU_ADD;
        i_alu = 1'b1;
        case (opcode)
            6'h09: i_code = ALU_ADD;
            6'h0a: i_code = ALU_SLT;
            6'h0b: i_code = ALU_SLTU;
            6'h0c: i_code = ALU_AND;
            6'h0d: i_code = ALU_OR;
            6'h0e: i_code = ALU_XOR;
            default: i_alu = 1'b0;
        endcase
    end
    // ANDI/ORI/XORI (opcode bit 2 set) take the zero-extended immediate
    assign i_srcb   = opcode[2] ? 2'd2 : 2'd1;
    assign is_r     = opcode == 6'h00;
    assign is_jr    = is_r && funct == 6'h08;
    assign is_jalr  = is_r && funct == 6'h09;
    assign is_shift = is_r && (funct == 6'h00 || funct == 6'h02 || funct == 6'h03);
    assign is_lw    = opcode == 6'h23;
    assign is_sw    = opcode == 6'h2b;
    assign is_br    = opcode[5:2] == 4'b0001;
    assign is_j     = opcode == 6'h02;
    assign is_jal   = opcode == 6'h03;
    assign legal    = is_r ? r_legal : (i_alu || is_lw || is_sw || is_br || is_j || is_jal);
    // odd branch opcodes (BNE/BGTZ) take on a false compare
    assign br_take  = alu_bit0 ^ opcode[0];
    always_comb begin
        state_d = state_q;
        illegal_d = illegal_q;
        alu_control = ALU_AND;
        alu_src_a = 2'd0;
        alu_src_b = 2'd0;
        mem_read = 1'b0;
        mem_write = 1'b0;
        addr_sel = 1'b0;
        ir_write = 1'b0;
        pc_write = 1'b0;
        reg_write = 1'b0;
        reg_dst = 2'd0;
        wb_sel = 1'b0;
        pc_src = 2'd0;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    mem_read = 1'b1;
                    ir_write = !waitrequest;
                    pc_write = !waitrequest;
                    state_d = waitrequest ? FETCH : DECODE;
                end
                DECODE: begin
                    alu_src_b = 2'd3;
                    alu_control = ALU_ADD;
                    state_d = legal ? EXEC : HALT;
                    illegal_d = illegal_q | ~legal;
                end
                EXEC: begin
                    alu_src_a = is_shift ? 2'd2 : (is_jalr || is_jal) ? 2'd0 : 2'd1;
                    alu_src_b = i_alu ? i_srcb : (is_lw || is_sw) ? 2'd1 : 2'd0;
                    alu_control = is_r ? r_code : i_alu ? i_code : is_br ? (opcode[1] ? ALU_LEZ : ALU_EQ) :
                                  is_jal ? ALU_LINK : ALU_ADD;
                    pc_write = is_jr || is_jalr || is_j || is_jal || (is_br && br_take);
                    pc_src = (is_jr || is_jalr) ? 2'd3 : (is_j || is_jal) ? 2'd2 : is_br ? 2'd1 : 2'd0;
                    state_d = (is_lw || is_sw) ? MEM : (is_br || is_j) ? FETCH :
                              is_jr ? (rs_is_zero ? HALT : FETCH) : WB;
                end
                MEM: begin
                    addr_sel = 1'b1;
                    mem_read = is_lw;
                    mem_write = is_sw;
                    state_d = waitrequest ? MEM : is_lw ? WB : FETCH;
                end
                WB: begin
                    reg_write = 1'b1;
                    reg_dst = is_jal ? 2'd2 : is_r ? 2'd1 : 2'd0;
                    wb_sel = is_lw;
                    state_d = FETCH;
                end
                default: state_d = state_q;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            illegal_q <= illegal_d;
        end
    end
    assign active  = state_q != HALT;
    assign illegal = illegal_q;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: scoreboard bench comparing every cycle's outputs against a phase-sequence model.
module tb_mips_multicycle_control;
    typedef struct {
        string       nm;
        logic [21:0] val;
        logic [21:0] mask;
    } exp_t;
    localparam int LSB [14] = '{17, 15, 13, 12, 11, 10, 9, 8, 7, 5, 4, 2, 1, 0};
    localparam int WID [14] = '{5, 2, 2, 1, 1, 1, 1, 1, 1, 2, 1, 2, 1, 1};
    localparam int OTHER_OPS [8] = '{'h02, 'h03, 'h04, 'h05, 'h06, 'h07, 'h23, 'h2B};
    logic       clk = 1'b0, reset = 1'b1;
    logic [5:0] opcode = '0, funct = '0;
    logic       rs_is_zero = 1'b0, alu_bit0 = 1'b0, waitrequest = 1'b0;
    logic [4:0] alu_control;
    logic [1:0] alu_src_a, alu_src_b, reg_dst, pc_src;
    logic       mem_read, mem_write, addr_sel, ir_write, pc_write, reg_write, wb_sel, active, illegal;
    logic [21:0] dut_vec;
    exp_t       sb[$];
    exp_t       cur;
    int         r_code[int];
    int         i_code[int];
    logic [11:0] legal_tab[$];
    int         checks = 0, failures = 0;

    mips_multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .rs_is_zero(rs_is_zero),
        .alu_bit0(alu_bit0), .waitrequest(waitrequest), .alu_control(alu_control),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .mem_read(mem_read), .mem_write(mem_write),
        .addr_sel(addr_sel), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .wb_sel(wb_sel), .pc_src(pc_src), .active(active), .illegal(illegal)
    );

    always #5 clk = ~clk;
    assign dut_vec = {alu_control, alu_src_a, alu_src_b, mem_read, mem_write, addr_sel, ir_write,
                      pc_write, reg_write, reg_dst, wb_sel, pc_src, active, illegal};

    // a field given as -1 is not checked
    function automatic exp_t mk(string nm, int alu, int sa, int sbs, int mr, int mw, int as, int irw,
                                int pcw, int rw, int rd, int wb, int ps, int act, int ill);
        int v[14];
        exp_t e;
        v = '{alu, sa, sbs, mr, mw, as, irw, pcw, rw, rd, wb, ps, act, ill};
        e.nm = nm;
        e.val = '0;
        e.mask = '0;
        for (int i = 0; i < 14; i++)
            if (v[i] >= 0) begin
                e.val |= 22'(v[i]) << LSB[i];
                e.mask |= 22'((1 << WID[i]) - 1) << LSB[i];
            end
        return e;
    endfunction

    function automatic bit is_legal(logic [5:0] op, logic [5:0] fn);
        if (op == 6'h00) return r_code.exists(int'(fn)) || fn == 6'h08 || fn == 6'h09;
        if (i_code.exists(int'(op))) return 1'b1;
        foreach (OTHER_OPS[i]) if (int'(op) == OTHER_OPS[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic exp_t expect_phase(byte ph, bit wr, logic [5:0] op, logic [5:0] fn, bit b0, bit ill);
        bit lw, sw, take;
        int rd;
        lw = op == 6'h23;
        sw = op == 6'h2B;
        take = (op == 6'h04 || op == 6'h06) ? b0 : !b0;
        rd = op == 6'h03 ? 2 : op == 6'h00 ? 1 : 0;
        case (ph)
            "F": return mk("fetch", -1, -1, -1, 1, 0, 0, !wr, !wr, 0, -1, -1, wr ? -1 : 0, 1, 0);
            "D": return mk("decode", -1, -1, -1, 0, 0, -1, 0, 0, 0, -1, -1, -1, 1, 0);
            "M": return mk("mem", -1, -1, -1, lw, sw, 1, 0, 0, 0, -1, -1, -1, 1, 0);
            "W": return mk("writeback", -1, -1, -1, 0, 0, -1, 0, 0, 1, rd, lw, -1, 1, 0);
            "H": return mk("halt", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ill);
            default: begin
                if (op == 6'h00 && fn == 6'h08)
                    return mk("exec_jr", -1, -1, -1, 0, 0, -1, 0, 1, 0, -1, -1, 3, 1, 0);
                if (op == 6'h00 && fn == 6'h09)
                    return mk("exec_jalr", 'b01011, 0, -1, 0, 0, -1, 0, 1, 0, -1, -1, 3, 1, 0);
                if (op == 6'h00)
                    return mk("exec_r", r_code[int'(fn)], fn <= 6'h03 ? 2 : 1, 0, 0, 0, -1, 0, 0, 0, -1, -1, -1, 1, 0);
                if (i_code.exists(int'(op)))
                    return mk("exec_i", i_code[int'(op)], 1, op >= 6'h0C ? 2 : 1, 0, 0, -1, 0, 0, 0, -1, -1, -1, 1, 0);
                if (lw || sw)
                    return mk("exec_ls", 'b00010, 1, 1, 0, 0, -1, 0, 0, 0, -1, -1, -1, 1, 0);
                if (op == 6'h02)
                    return mk("exec_j", -1, -1, -1, 0, 0, -1, 0, 1, 0, -1, -1, 2, 1, 0);
                if (op == 6'h03)
                    return mk("exec_jal", 'b01011, 0, -1, 0, 0, -1, 0, 1, 0, -1, -1, 2, 1, 0);
                return mk("exec_branch", op >= 6'h06 ? 'b10000 : 'b01010, -1, -1, 0, 0, -1, 0, take, 0,
                          -1, -1, take ? 1 : -1, 1, 0);
            end
        endcase
    endfunction

    function automatic int wait_len();
        return $urandom_range(0, 2) == 0 ? int'($urandom_range(1, 3)) : 0;
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        waitrequest = 1'($urandom);
        sb.push_back(mk("reset_cycle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, -1));
        @(posedge clk);
        #1;
        sb.push_back(mk("reset_state", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    endtask

    // rst_at: phase index at which reset interrupts the instruction (-1 for none)
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int wf, input int wm,
                             input bit b0, input bit rz, input int rst_at, input int nhalt);
        byte ph[$];
        bit  wq[$];
        bit  legal, lw, sw, halts, wbk;
        legal = is_legal(op, fn);
        lw = op == 6'h23;
        sw = op == 6'h2B;
        halts = !legal || (op == 6'h00 && fn == 6'h08 && rz);
        wbk = lw || (op == 6'h00 && fn != 6'h08) || i_code.exists(int'(op)) || op == 6'h03;
        for (int i = 0; i <= wf; i++) begin ph.push_back("F"); wq.push_back(i < wf); end
        ph.push_back("D"); wq.push_back(1'($urandom));
        if (legal) begin
            ph.push_back("E"); wq.push_back(1'($urandom));
            if (lw || sw)
                for (int i = 0; i <= wm; i++) begin ph.push_back("M"); wq.push_back(i < wm); end
            if (wbk) begin ph.push_back("W"); wq.push_back(1'($urandom)); end
        end
        if (halts)
            for (int i = 0; i < nhalt; i++) begin ph.push_back("H"); wq.push_back(1'($urandom)); end
        for (int k = 0; k < ph.size(); k++) begin
            if (k == rst_at) begin
                do_reset();
                return;
            end
            @(posedge clk);
            #1;
            reset = 1'b0;
            waitrequest = wq[k];
            alu_bit0 = b0;
            rs_is_zero = rz;
            opcode = ph[k] == "F" ? 6'($urandom) : op;
            funct = ph[k] == "F" ? 6'($urandom) : fn;
            sb.push_back(expect_phase(ph[k], wq[k], op, fn, b0, !legal));
        end
        if (halts) do_reset();
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            checks++;
            if (((dut_vec ^ cur.val) & cur.mask) != '0) begin
                failures++;
                $display("FAIL %s at %0t: got %h required %h (compared bits %h)", cur.nm, $time,
                         dut_vec & cur.mask, cur.val, cur.mask);
            end
        end
    end

    initial begin
        logic [11:0] ent;
        logic [5:0]  op, fn;
        r_code['h21] = 'b00010; r_code['h23] = 'b00110; r_code['h24] = 'b00000; r_code['h25] = 'b00001;
        r_code['h26] = 'b00011; r_code['h2A] = 'b00111; r_code['h2B] = 'b01001;
        r_code['h00] = 'b00100; r_code['h02] = 'b00101; r_code['h03] = 'b01000;
        i_code['h09] = 'b00010; i_code['h0A] = 'b00111; i_code['h0B] = 'b01001;
        i_code['h0C] = 'b00000; i_code['h0D] = 'b00001; i_code['h0E] = 'b00011;
        foreach (r_code[k]) legal_tab.push_back({6'h00, 6'(k)});
        legal_tab.push_back({6'h00, 6'h08});
        legal_tab.push_back({6'h00, 6'h09});
        foreach (i_code[k]) legal_tab.push_back({6'(k), 6'h00});
        foreach (OTHER_OPS[i]) legal_tab.push_back({6'(OTHER_OPS[i]), 6'h00});
        do_reset();
        run_instr(6'h00, 6'h21, 0, 0, 1'b0, 1'b0, -1, 0);
        run_instr(6'h23, 6'h00, 0, 2, 1'b0, 1'b0, -1, 0);
        run_instr(6'h05, 6'h00, 0, 0, 1'b0, 1'b0, -1, 0);
        run_instr(6'h05, 6'h00, 0, 0, 1'b1, 1'b0, -1, 0);
        run_instr(6'h00, 6'h08, 0, 0, 1'b0, 1'b1, -1, 20);
        run_instr(6'h3F, 6'h00, 1, 0, 1'b0, 1'b0, -1, 5);
        run_instr(6'h2B, 6'h00, 0, 5, 1'b0, 1'b0, 4, 0);
        run_instr(6'h00, 6'h25, 0, 0, 1'b0, 1'b0, -1, 0);
        repeat (250) begin
            if ($urandom_range(0, 15) == 0) begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end else begin
                ent = legal_tab[$urandom_range(0, legal_tab.size() - 1)];
                op = ent[11:6];
                fn = op == 6'h00 ? ent[5:0] : 6'($urandom);
            end
            run_instr(op, fn, wait_len(), wait_len(), 1'($urandom), $urandom_range(0, 3) == 0,
                      $urandom_range(0, 19) == 0 ? int'($urandom_range(0, 8)) : -1, $urandom_range(1, 4));
        end
        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
